// File: rtl/conv_sequencer.sv
// Multi-channel read/convolve sequencer: each channel is a counted read burst,
// a one-cycle conv_start pulse, then a bounded wait for conv_done.
module conv_sequencer #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024,
    localparam int CH_W   = $clog2(N_CH + 1),
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int TW     = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_operation,
    input  logic             abort,
    input  logic [CH_W-1:0]  ch_count,
    input  logic [CNT_W-1:0] read_len,
    input  logic             read_valid,
    input  logic             conv_done,
    output logic             read_enable,
    output logic [IDX_W-1:0] read_channel,
    output logic             conv_start,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CONV_START,
        CONV_WAIT,
        DONE,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] rd_len_q, rd_len_d;
    logic [CH_W-1:0]  ch_cnt_q, ch_cnt_d;
    logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             read_enable_q, read_enable_d;
    logic             conv_start_q, conv_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic [CH_W-1:0]  ch_idx_ext;
    logic [TW-1:0]    timer_inc;
    logic             last_ch;

    assign ch_idx_ext = CH_W'(ch_idx_q);
    assign last_ch    = ((ch_idx_ext + CH_W'(1)) == ch_cnt_q);
    // Saturating increment: the timer never wraps even if held in CONV_WAIT.
    assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + TW'(1);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rd_len_d = rd_len_q;
        ch_cnt_d = ch_cnt_q;
        ch_idx_d = ch_idx_q;
        timer_d  = timer_q;
        error_d  = error_q;

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_operation) begin
                        rd_len_d = read_len;
                        ch_cnt_d = ch_count;
                        ch_idx_d = '0;
                        beat_d   = '0;
                        error_d  = 1'b0;
                        if ((ch_count == '0) || (ch_count > CH_W'(N_CH)) || (read_len == '0)) begin
                            state_d = ERR;
                            error_d = 1'b1;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
                READ: begin
                    if (read_valid) begin
                        if (beat_q == rd_len_q - CNT_W'(1)) begin
                            state_d = CONV_START;
                        end else begin
                            beat_d = beat_q + CNT_W'(1);
                        end
                    end
                end
                CONV_START: begin
                    timer_d = '0;
                    state_d = CONV_WAIT;
                end
                CONV_WAIT: begin
                    timer_d = timer_inc;
                    // A completion in the same cycle as the timeout still wins.
                    if (conv_done) begin
                        if (last_ch) begin
                            state_d = DONE;
                        end else begin
                            ch_idx_d = ch_idx_q + IDX_W'(1);
                            beat_d   = '0;
                            state_d  = READ;
                        end
                    end else if (timer_inc == TW'(TIMEOUT - 1)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                ERR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        read_enable_d = (state_d == READ);
        conv_start_d  = (state_d == CONV_START);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            rd_len_q      <= '0;
            ch_cnt_q      <= '0;
            ch_idx_q      <= '0;
            timer_q       <= '0;
            read_enable_q <= 1'b0;
            conv_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            rd_len_q      <= rd_len_d;
            ch_cnt_q      <= ch_cnt_d;
            ch_idx_q      <= ch_idx_d;
            timer_q       <= timer_d;
            read_enable_q <= read_enable_d;
            conv_start_q  <= conv_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign read_enable  = read_enable_q;
    assign read_channel = ch_idx_q;
    assign conv_start   = conv_start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
